// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: circular RAM, occupancy count, registered read port with valid strobe.
// Define FIFO_ERR_FLAG_EN to add the sticky overflow/underflow flags and their ports.
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  fifo_cnt
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q;
  logic              rd_acc, wr_acc;

  // Flags decode from the registered count, so they move the cycle after an access.
  assign fifo_empty   = (cnt_q == '0);
  assign fifo_full    = (cnt_q == FULL_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign fifo_cnt     = cnt_q;
  assign dout         = dout_q;
  assign dout_vld     = dout_vld_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc = rd_en & ~fifo_empty;
    wr_acc = wr_en & (~fifo_full | rd_acc);
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_acc) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      dout_vld_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem_q[rptr_q];
      end
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en & fifo_full & ~rd_acc);
    underflow_d = underflow_q | (rd_en & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
